// File: rtl/mem_access_unit_if.sv
// Signal bundle for mem_access_unit: request/response handshake plus data-memory port.
// The slave modport is the unit; the master modport is the requester/memory side.
interface mem_access_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;

   logic [31:0] mem_address;
   logic        mem_enable;
   logic        mem_write_enable;
   logic [31:0] mem_write_data;
   logic [31:0] mem_data_out;

   modport slave (
      input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
      input  rsp_ready, mem_data_out,
      output req_ready, rsp_valid, rsp_data, rsp_err,
      output mem_address, mem_enable, mem_write_enable, mem_write_data
   );

   modport master (
      output req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
      output rsp_ready, mem_data_out,
      input  req_ready, rsp_valid, rsp_data, rsp_err,
      input  mem_address, mem_enable, mem_write_enable, mem_write_data
   );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a word-wide data memory; sub-word stores use read-modify-write.
// Optional MAU_MISALIGN_TRAP_EN: misaligned requests answer with rsp_err instead of being aligned.
module mem_access_unit (
   input logic              clk,
   input logic              rst_n,
   mem_access_unit_if.slave bus
);
   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 14;  // byte-address bits that reach the 4K-word memory
   localparam int unsigned HW   = 16;

   typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [HW-1:0]   wdata_q, wdata_d;
   logic [1:0]      size_q, size_d;
   logic            signed_q, signed_d;
   logic            store_q, store_d;
   logic            req_ready_q, req_ready_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic            rsp_err_q, rsp_err_d;
   logic [XLEN-1:0] rsp_data_q, rsp_data_d;
   logic            mem_en_q, mem_en_d;
   logic            mem_we_q, mem_we_d;
   logic [XLEN-1:0] mem_addr_q, mem_addr_d;
   logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
   logic            unused_addr_hi;

   assign unused_addr_hi = ^bus.req_addr[XLEN-1:AW];

   function automatic logic [AW-1:0] align_addr(input logic [AW-1:0] a, input logic [1:0] size);
      logic [AW-1:0] r;
      r = a;
      if (size == 2'b01) r[0] = 1'b0;
      else if (size[1]) r[1:0] = 2'b00;
      return r;
   endfunction

   function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word, input logic [1:0] size,
                                                    input logic [1:0] lo, input logic sgn);
      logic [7:0]      b;
      logic [HW-1:0]   h;
      logic [XLEN-1:0] r;
      b = 8'(word >> {lo, 3'b000});
      h = HW'(word >> {lo[1], 4'b0000});
      unique case (size)
         2'b00:   r = {{24{sgn & b[7]}}, b};
         2'b01:   r = {{16{sgn & h[HW-1]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [XLEN-1:0] merge_lane(input logic [XLEN-1:0] old, input logic [HW-1:0] wd,
                                                  input logic [1:0] size, input logic [1:0] lo);
      logic [XLEN-1:0] mask;
      logic [XLEN-1:0] ins;
      if (size == 2'b00) begin
         mask = XLEN'(8'hFF) << {lo, 3'b000};
         ins  = XLEN'(wd[7:0]) << {lo, 3'b000};
      end else begin
         mask = XLEN'(16'hFFFF) << {lo[1], 4'b0000};
         ins  = XLEN'(wd) << {lo[1], 4'b0000};
      end
      return (old & ~mask) | ins;
   endfunction

`ifdef MAU_MISALIGN_TRAP_EN
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      logic r;
      if (size == 2'b01) r = lo[0];
      else if (size[1])  r = (lo != 2'b00);
      else               r = 1'b0;
      return r;
   endfunction
`endif

   // Next-state and next-output logic; every output flop is loaded from the next state.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      size_d      = size_q;
      signed_d    = signed_q;
      store_d     = store_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      mem_wdata_d = '0;

      unique case (state_q)
         IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               addr_d     = align_addr(bus.req_addr[AW-1:0], bus.req_size);
               wdata_d    = bus.req_wdata[HW-1:0];
               size_d     = bus.req_size;
               signed_d   = bus.req_signed;
               store_d    = bus.req_store;
               rsp_data_d = '0;
               rsp_err_d  = 1'b0;
               if (!bus.req_store || !bus.req_size[1]) begin
                  state_d = RD;
               end else begin
                  state_d     = WR;
                  mem_wdata_d = bus.req_wdata;
               end
`ifdef MAU_MISALIGN_TRAP_EN
               if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                  state_d     = RESP;
                  rsp_err_d   = 1'b1;
                  mem_wdata_d = '0;
               end
`endif
            end
         end
         RD: begin
            if (store_q) begin
               state_d     = WR;
               mem_wdata_d = merge_lane(bus.mem_data_out, wdata_q, size_q, addr_q[1:0]);
            end else begin
               state_d    = RESP;
               rsp_data_d = load_extract(bus.mem_data_out, size_q, addr_q[1:0], signed_q);
            end
         end
         WR:      state_d = RESP;
         RESP:    if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
      mem_en_d    = (state_d == RD) || (state_d == WR);
      mem_we_d    = (state_d == WR);
      mem_addr_d  = mem_en_d ? XLEN'(addr_d[AW-1:2]) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         size_q      <= '0;
         signed_q    <= 1'b0;
         store_q     <= 1'b0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
         store_q     <= store_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_data_q  <= rsp_data_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign bus.req_ready        = req_ready_q;
   assign bus.rsp_valid        = rsp_valid_q;
   assign bus.rsp_data         = rsp_data_q;
   assign bus.rsp_err          = rsp_err_q;
   assign bus.mem_enable       = mem_en_q;
   assign bus.mem_write_enable = mem_we_q;
   assign bus.mem_address      = mem_addr_q;
   assign bus.mem_write_data   = mem_wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array reference model, falling-edge memory, directed vectors.
module tb_mem_access_unit;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_access_unit_if bus ();
   mem_access_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks = 0;
   int fails  = 0;

   logic [31:0] phys [0:4095];
   logic [7:0]  gb   [0:16383];
   int          en_cnt, we_cnt;
   logic [31:0] last_addr, last_wdata;
   logic        in_txn;

   logic [31:0] exp_data, exp_wdata, exp_widx;
   logic        exp_err, exp_trap;
   int          exp_lat, exp_nen, exp_nwe, exp_ba, exp_nb;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, req, $time);
      end
   endtask

   // Word memory: samples on the falling edge, read data ready for the next rising edge.
   always @(negedge clk) begin
      if (bus.mem_enable) begin
         en_cnt++;
         last_addr = bus.mem_address;
         if (bus.mem_write_enable) begin
            we_cnt++;
            last_wdata = bus.mem_write_data;
            phys[bus.mem_address[11:0]] = bus.mem_write_data;
         end
         bus.mem_data_out = phys[bus.mem_address[11:0]];
      end
   end

   // Per-cycle comparison of DUT outputs against the model's current expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.rsp_valid) begin
            check("rsp_data", bus.rsp_data, exp_data);
            check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
         end
         if (bus.mem_enable) check("mem_address", bus.mem_address, exp_widx);
         if (bus.mem_write_enable) begin
            check("mem_write_data", bus.mem_write_data, exp_wdata);
            check("we_needs_en", 32'(bus.mem_enable), 32'd1);
         end
         if (!in_txn) check("idle_mem_enable", 32'(bus.mem_enable), 32'd0);
      end
   end

   // Reference: memory as little-endian bytes, requests described by size in bytes.
   task automatic model(input logic st, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
      int nb, ba, wb, off;
      logic [31:0] v;
      logic [7:0]  b;
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      ba = int'(a[13:0]);
      exp_trap = 1'b0;
      exp_nb   = nb;
`ifdef MAU_MISALIGN_TRAP_EN
      if (ba % nb != 0) begin
         exp_trap = 1'b1;
         exp_data = 32'd0;
         exp_err  = 1'b1;
         exp_lat  = 1;
         exp_nen  = 0;
         exp_nwe  = 0;
         return;
      end
`endif
      ba       = ba - (ba % nb);
      wb       = ba - (ba % 4);
      off      = ba - wb;
      exp_ba   = ba;
      exp_err  = 1'b0;
      exp_widx = 32'(wb / 4);
      if (!st) begin
         v = 32'd0;
         for (int k = 0; k < nb; k++) v = v | (32'(gb[ba + k]) << (8 * k));
         if (sg && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
         exp_data = v;
         exp_lat  = 2;
         exp_nen  = 1;
         exp_nwe  = 0;
      end else begin
         v = 32'd0;
         for (int k = 0; k < 4; k++) begin
            b = (k >= off && k < off + nb) ? wd[8 * (k - off) +: 8] : gb[wb + k];
            v = v | (32'(b) << (8 * k));
         end
         exp_wdata = v;
         exp_data  = 32'd0;
         exp_lat   = (nb == 4) ? 2 : 3;
         exp_nen   = (nb == 4) ? 1 : 2;
         exp_nwe   = 1;
      end
   endtask

   task automatic do_req(input string name, input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input int hold,
                         output logic [31:0] got);
      int waited, mlat;
      @(negedge clk);
      waited = 0;
      while (!bus.req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check({name, ":ready_before"}, 32'(bus.req_ready), 32'd1);
      model(st, sz, sg, a, wd);
      en_cnt         = 0;
      we_cnt         = 0;
      in_txn         = 1'b1;
      bus.req_valid  = 1'b1;
      bus.req_store  = st;
      bus.req_size   = sz;
      bus.req_signed = sg;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      bus.rsp_ready  = (hold == 0);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      mlat = 0;
      do begin
         @(negedge clk);
         mlat++;
      end while (!bus.rsp_valid && mlat < 8);
      check({name, ":latency"}, 32'(mlat), 32'(exp_lat));
      got = bus.rsp_data;
      for (int i = 0; i < hold; i++) begin
         check({name, ":bp_req_ready"}, 32'(bus.req_ready), 32'd0);
         check({name, ":bp_mem_enable"}, 32'(bus.mem_enable), 32'd0);
         check({name, ":bp_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
         @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check({name, ":ready_after"}, 32'(bus.req_ready), 32'd1);
      check({name, ":valid_after"}, 32'(bus.rsp_valid), 32'd0);
      check({name, ":mem_reads"}, 32'(en_cnt), 32'(exp_nen));
      check({name, ":mem_writes"}, 32'(we_cnt), 32'(exp_nwe));
      in_txn = 1'b0;
      if (st && !exp_trap)
         for (int k = 0; k < exp_nb; k++) gb[exp_ba + k] = wd[8 * k +: 8];
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] w;
      rst_n            = 1'b0;
      in_txn           = 1'b1;
      bus.req_valid    = 1'b0;
      bus.req_store    = 1'b0;
      bus.req_size     = 2'd0;
      bus.req_signed   = 1'b0;
      bus.req_addr     = 32'd0;
      bus.req_wdata    = 32'd0;
      bus.rsp_ready    = 1'b1;
      bus.mem_data_out = 32'd0;
      exp_data = 0; exp_wdata = 0; exp_widx = 0; exp_err = 0; exp_trap = 0;
      exp_lat = 0; exp_nen = 0; exp_nwe = 0; exp_ba = 0; exp_nb = 1;
      en_cnt = 0; we_cnt = 0; last_addr = 0; last_wdata = 0;
      for (int i = 0; i < 4096; i++) begin
         w = 32'hC0DE_0000 | 32'(i);
         phys[i] = w;
         for (int k = 0; k < 4; k++) gb[4 * i + k] = w[8 * k +: 8];
      end

      #12;
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_data", bus.rsp_data, 32'd0);
      check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      check("rst_mem_enable", 32'(bus.mem_enable), 32'd0);
      check("rst_mem_we", 32'(bus.mem_write_enable), 32'd0);
      check("rst_mem_address", bus.mem_address, 32'd0);
      check("rst_mem_wdata", bus.mem_write_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_req_ready_low", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
      check("rel_req_ready_first_edge", 32'(bus.req_ready), 32'd1);
      in_txn = 1'b0;

      do_req("st_w10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, got);
      check("lit_st_w10_data", last_wdata, 32'hDEAD_BEEF);
      do_req("ld_w10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, got);
      check("lit_ld_w10", got, 32'hDEAD_BEEF);
      check("lit_ld_w10_addr", last_addr, 32'd4);
      do_req("st_b12", 1'b1, 2'd0, 1'b0, 32'h12, 32'h55, 0, got);
      check("lit_rmw_wdata", last_wdata, 32'hDE55_BEEF);
      check("lit_rmw_en_cycles", 32'(en_cnt), 32'd2);
      check("lit_rmw_we_cycles", 32'(we_cnt), 32'd1);
      do_req("ld_hs12", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, got);
      check("lit_ld_hs12", got, 32'hFFFF_DE55);
      do_req("ld_hu12", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0, got);
      check("lit_ld_hu12", got, 32'h0000_DE55);
      do_req("bp_ldb13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 5, got);
      check("lit_bp_ldb13", got, 32'h0000_00DE);
      do_req("ld_w13_mis", 1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 0, got);
`ifdef MAU_MISALIGN_TRAP_EN
      check("lit_mis_data", got, 32'h0);
      check("lit_mis_no_mem", 32'(en_cnt), 32'd0);
`else
      check("lit_mis_data", got, 32'hDE55_BEEF);
`endif
      do_req("ld_bs11", 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 0, got);
      check("lit_ld_bs11", got, 32'hFFFF_FFBE);
      do_req("st_h16", 1'b1, 2'd1, 1'b0, 32'h16, 32'h0000_1234, 0, got);
      do_req("ld_w14", 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 0, got);
      check("lit_ld_w14", got, 32'h1234_0005);
      do_req("ld_sz3_14", 1'b0, 2'd3, 1'b1, 32'h14, 32'h0, 0, got);
      check("lit_ld_sz3_14", got, 32'h1234_0005);
      do_req("st_h21_mis", 1'b1, 2'd1, 1'b0, 32'h21, 32'h0000_ABCD, 0, got);
      do_req("ld_w20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, got);
`ifdef MAU_MISALIGN_TRAP_EN
      check("lit_ld_w20", got, 32'hC0DE_0008);
`else
      check("lit_ld_w20", got, 32'hC0DE_ABCD);
`endif

      // Reset while a byte read-modify-write sits in its write cycle.
      @(negedge clk);
      model(1'b1, 2'd0, 1'b0, 32'h31, 32'h99);
      en_cnt         = 0;
      we_cnt         = 0;
      in_txn         = 1'b1;
      bus.req_valid  = 1'b1;
      bus.req_store  = 1'b1;
      bus.req_size   = 2'd0;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'h31;
      bus.req_wdata  = 32'h99;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("rmw_in_wr", 32'(bus.mem_write_enable), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rmw_rst_we", 32'(bus.mem_write_enable), 32'd0);
      check("rmw_rst_en", 32'(bus.mem_enable), 32'd0);
      check("rmw_rst_addr", bus.mem_address, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("rmw_reads", 32'(en_cnt), 32'd1);
      check("rmw_writes", 32'(we_cnt), 32'd0);
      @(posedge clk);
      #1;
      check("rmw_ready_after_rst", 32'(bus.req_ready), 32'd1);
      in_txn = 1'b0;
      do_req("ld_w30", 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 0, got);
      check("lit_ld_w30_unchanged", got, 32'hC0DE_000C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports, clock and reset first: clk input 1 (single clock; all state on rising edge); rst_n input 1 (asynchronous, active-low).
REQ-002 SHALL have request ports: req_valid in 1; req_ready out 1; req_store in 1 (1=store, 0=load); req_size in 2 (00 byte, 01 half, 10 word, 11 treated as word); req_signed in 1 (load sign-extend); req_addr in 32 (byte address); req_wdata in 32.
REQ-003 SHALL have response ports: rsp_valid out 1; rsp_ready in 1; rsp_data out 32 (load result, 0 for stores); rsp_err out 1 (misaligned).
REQ-004 SHALL have data-memory ports: mem_address out 32; mem_enable out 1; mem_write_enable out 1; mem_write_data out 32; mem_data_out in 32 (the memory samples on the falling edge; read data is stable by the next rising edge).

Function
REQ-005 SHALL implement states IDLE, RD, WR, RESP.
REQ-006 SHALL assert req_ready only in IDLE; a request is accepted when req_valid && req_ready, latching addr, wdata, size, signed and store.
REQ-007 SHALL go on accept: load -> RD; word store -> WR; byte/half store -> RD (read-modify-write).
REQ-008 SHALL drive mem_address = {20'b0, addr[13:2]} (word index) in RD and WR, and 0 elsewhere.
REQ-009 SHALL drive mem_enable=1 in RD and WR only, and mem_write_enable=1 in WR only; both decoded from the state register, glitch-free.
REQ-010 SHALL go from RD to RESP for loads, capturing the extracted and extended mem_data_out into rsp_data at that rising edge.
REQ-011 SHALL go from RD to WR for sub-word stores, capturing mem_data_out into a merge register.
REQ-012 SHALL, in WR, drive mem_write_data = the full req_wdata for word stores; for sub-word stores it is the merge register with the lane at addr[1:0] (byte) or addr[1] (half) replaced by req_wdata[7:0] or [15:0]. WR -> RESP.
REQ-013 SHALL select load lanes as for stores (little-endian), zero-extended or, if req_signed, sign-extended to 32 bits; a word load passes through.
REQ-014 SHALL hold RESP with rsp_valid=1 and rsp_data/rsp_err stable until rsp_ready=1, then go to IDLE; no new request is accepted in the same cycle.
REQ-015 SHALL have latency accept->rsp_valid of 2 cycles for loads and word stores, and 3 cycles for sub-word stores; throughput is one request per latency+1 cycles with rsp_ready held high.
REQ-016 SHALL treat a request as misaligned when half has addr[0]!=0 or word has addr[1:0]!=0; its handling is defined in REQ-020/021.

Reset
REQ-017 SHALL, while rst_n=0 (asynchronous assertion), force state=IDLE, with req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, mem_enable=0, mem_write_enable=0, mem_address=0, mem_write_data=0, and all latches cleared.
REQ-018 SHALL make req_ready=1 on the first rising edge after rst_n deassertion.
REQ-019 SHALL abort a reset asserted mid-RMW with no write issued; the memory word is left unmodified.

Configuration
REQ-020 SHALL, with MAU_MISALIGN_TRAP_EN defined, send a misaligned request from IDLE straight to RESP with rsp_err=1 and rsp_data=0, with no mem_enable pulse.
REQ-021 SHALL, without MAU_MISALIGN_TRAP_EN, force addr low bits to the aligned value (half: bit0=0; word: bits1:0=0), proceed normally, and tie rsp_err to 0.

Verification
REQ-022 SHALL cover word store then load: store addr 0x10 data 0xDEADBEEF, then load word 0x10 -> mem_address=4, rsp_data=0xDEADBEEF, 2 cycles after accept.
REQ-023 SHALL cover byte RMW: word 0x10=0xDEADBEEF; store byte 0x12 data 0x55 -> exactly one read then one write of 0xDE55BEEF; mem_enable is high 2 cycles, mem_write_enable 1 cycle.
REQ-024 SHALL cover signed load: load half signed 0x12 from 0xDE55BEEF -> rsp_data=0xFFFFDE55; unsigned -> 0x0000DE55.
REQ-025 SHALL cover backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, req_ready=0, no memory activity; 1 cycle after rsp_ready=1, req_ready=1.
REQ-026 SHALL cover misaligned word load 0x13: with the macro -> rsp_err=1, no mem_enable; without -> word 0x10 returned, rsp_err=0.
REQ-027 SHALL cover reset in WR of a byte RMW: rst_n low -> mem_write_enable=0 immediately, and the word is unchanged on readback.
